// File: rtl/wphy_drvr_cal_pkg.sv
// Shared types and constants for the driver calibration update sequencer.
// Holds the code widths, reset codes, FSM state encoding and the per-slice code bundle.
package wphy_drvr_cal_pkg;

    localparam int PCAL_W = 6;
    localparam int NCAL_W = 5;
    localparam int IMPD_W = 3;
    localparam int OVRD_W = 3;
    localparam int ODT_W  = 2;

    localparam logic [PCAL_W-1:0] PCAL_RST = 6'h20;
    localparam logic [NCAL_W-1:0] NCAL_RST = 5'h10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FREEZE   = 3'd1,
        ST_SET_PRE  = 3'd2,
        ST_APPLY    = 3'd3,
        ST_SET_POST = 3'd4,
        ST_RELEASE  = 3'd5
    } state_t;

    typedef struct packed {
        logic [PCAL_W-1:0] pcal;
        logic [NCAL_W-1:0] ncal;
        logic [IMPD_W-1:0] impd;
        logic [OVRD_W-1:0] ovrd;
        logic [ODT_W-1:0]  odt;
        logic              ucie;
    } drvr_code_t;

    function automatic drvr_code_t drvr_code_rst();
        drvr_code_t c;
        c.pcal = PCAL_RST;
        c.ncal = NCAL_RST;
        c.impd = {IMPD_W{1'b0}};
        c.ovrd = {OVRD_W{1'b0}};
        c.odt  = {ODT_W{1'b0}};
        c.ucie = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/wphy_drvr_cal_slice_reg.sv
// Code register for one driver slice: loads a full code bundle on i_load,
// otherwise holds; returns to the reset calibration codes on reset.
module wphy_drvr_cal_slice_reg
    import wphy_drvr_cal_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  drvr_code_t i_code,
    output drvr_code_t o_code
);

    drvr_code_t r_code;

    // Slice code register with synchronous reset to the default codes.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_code <= drvr_code_rst();
        end else if (i_load) begin
            r_code <= i_code;
        end else begin
            r_code <= r_code;
        end
    end

    assign o_code = r_code;

endmodule

// File: rtl/wphy_drvr_cal_update_seq.sv
// Glitch-free driver code update sequencer: freeze targeted slices, settle,
// load new codes, settle, release with a one-cycle ack. Also owns per-slice high-Z.
module wphy_drvr_cal_update_seq
    import wphy_drvr_cal_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int SETTLE_W = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_upd_req,
    output logic                     o_upd_ack,
    input  logic [NUM_CH-1:0]        i_upd_ch_mask,
    input  logic [PCAL_W-1:0]        i_upd_pcal,
    input  logic [NCAL_W-1:0]        i_upd_ncal,
    input  logic [IMPD_W-1:0]        i_upd_impd,
    input  logic [OVRD_W-1:0]        i_upd_ovrd,
    input  logic [ODT_W-1:0]         i_upd_odt,
    input  logic                     i_upd_ucie,
    input  logic [SETTLE_W-1:0]      i_settle_cyc,
    input  logic [NUM_CH-1:0]        i_highz_req,
    output logic                     o_busy,
    output logic [NUM_CH-1:0]        o_freeze_n,
    output logic [NUM_CH-1:0]        o_highz_n,
    output logic [NUM_CH*PCAL_W-1:0] o_pcal,
    output logic [NUM_CH*NCAL_W-1:0] o_ncal,
    output logic [NUM_CH*IMPD_W-1:0] o_impd,
    output logic [NUM_CH*OVRD_W-1:0] o_ovrd,
    output logic [NUM_CH*ODT_W-1:0]  o_odt,
    output logic [NUM_CH-1:0]        o_ucie
);

    localparam logic [SETTLE_W-1:0] CNT_ZERO = {SETTLE_W{1'b0}};
    localparam logic [SETTLE_W-1:0] CNT_ONE  = {{(SETTLE_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_next_state;
    logic [SETTLE_W-1:0] r_cnt;
    logic [SETTLE_W-1:0] w_cnt_nxt;
    logic [SETTLE_W-1:0] r_settle;
    logic [NUM_CH-1:0]   r_mask;
    drvr_code_t          r_shadow;
    logic                r_rearm;
    logic                w_rearm_nxt;
    logic                w_latch;
    logic [NUM_CH-1:0]   w_load;
    logic [NUM_CH-1:0]   r_freeze_n;
    logic [NUM_CH-1:0]   w_freeze_n_nxt;
    logic [NUM_CH-1:0]   r_highz_n;
    logic                r_ack;
    logic                w_ack_nxt;
    logic                r_busy;
    drvr_code_t          w_upd_code;
    drvr_code_t          w_code [NUM_CH];

    assign w_upd_code = '{pcal: i_upd_pcal, ncal: i_upd_ncal, impd: i_upd_impd,
                          ovrd: i_upd_ovrd, odt: i_upd_odt, ucie: i_upd_ucie};

    // Next-state, settle counter, freeze and ack decode.
    always_comb begin
        w_next_state   = r_state;
        w_cnt_nxt      = r_cnt;
        w_freeze_n_nxt = r_freeze_n;
        w_ack_nxt      = 1'b0;
        w_load         = {NUM_CH{1'b0}};
        w_latch        = 1'b0;
        w_rearm_nxt    = r_rearm | ~i_upd_req;
        case (r_state)
            ST_IDLE: begin
                if (i_upd_req && r_rearm) begin
                    w_latch     = 1'b1;
                    w_rearm_nxt = 1'b0;
                    if (i_upd_ch_mask == {NUM_CH{1'b0}}) begin
                        w_next_state = ST_RELEASE;
                    end else begin
                        w_next_state = ST_FREEZE;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_FREEZE: begin
                w_freeze_n_nxt = r_freeze_n & ~r_mask;
                w_cnt_nxt      = r_settle;
                if (r_settle == CNT_ZERO) begin
                    w_next_state = ST_APPLY;
                end else begin
                    w_next_state = ST_SET_PRE;
                end
            end
            // The last settle cycle is the one with the counter at 1; a zero
            // settle value bypasses this state entirely.
            ST_SET_PRE: begin
                if (r_cnt != CNT_ZERO) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else begin
                    w_cnt_nxt = CNT_ZERO;
                end
                if (r_cnt <= CNT_ONE) begin
                    w_next_state = ST_APPLY;
                end else begin
                    w_next_state = ST_SET_PRE;
                end
            end
            ST_APPLY: begin
                w_load    = r_mask;
                w_cnt_nxt = r_settle;
                if (r_settle == CNT_ZERO) begin
                    w_next_state = ST_RELEASE;
                end else begin
                    w_next_state = ST_SET_POST;
                end
            end
            ST_SET_POST: begin
                if (r_cnt != CNT_ZERO) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else begin
                    w_cnt_nxt = CNT_ZERO;
                end
                if (r_cnt <= CNT_ONE) begin
                    w_next_state = ST_RELEASE;
                end else begin
                    w_next_state = ST_SET_POST;
                end
            end
            ST_RELEASE: begin
                w_freeze_n_nxt = {NUM_CH{1'b1}};
                w_ack_nxt      = 1'b1;
                w_next_state   = ST_IDLE;
            end
            default: begin
                w_freeze_n_nxt = {NUM_CH{1'b1}};
                w_next_state   = ST_IDLE;
            end
        endcase
    end

    // FSM, counter and registered control outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= CNT_ZERO;
            r_rearm    <= 1'b1;
            r_freeze_n <= {NUM_CH{1'b1}};
            r_highz_n  <= {NUM_CH{1'b0}};
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_cnt_nxt;
            r_rearm    <= w_rearm_nxt;
            r_freeze_n <= w_freeze_n_nxt;
            r_highz_n  <= ~i_highz_req;
            r_ack      <= w_ack_nxt;
            r_busy     <= (w_next_state != ST_IDLE);
        end
    end

    // Shadow copy of the request, so inputs moving mid-update have no effect.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mask   <= {NUM_CH{1'b0}};
            r_settle <= CNT_ZERO;
            r_shadow <= drvr_code_rst();
        end else if (w_latch) begin
            r_mask   <= i_upd_ch_mask;
            r_settle <= i_settle_cyc;
            r_shadow <= w_upd_code;
        end else begin
            r_mask   <= r_mask;
            r_settle <= r_settle;
            r_shadow <= r_shadow;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slice
        wphy_drvr_cal_slice_reg u_slice_reg (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_load  (w_load[k]),
            .i_code  (r_shadow),
            .o_code  (w_code[k])
        );
        assign o_pcal[k*PCAL_W +: PCAL_W] = w_code[k].pcal;
        assign o_ncal[k*NCAL_W +: NCAL_W] = w_code[k].ncal;
        assign o_impd[k*IMPD_W +: IMPD_W] = w_code[k].impd;
        assign o_ovrd[k*OVRD_W +: OVRD_W] = w_code[k].ovrd;
        assign o_odt[k*ODT_W +: ODT_W]    = w_code[k].odt;
        assign o_ucie[k]                  = w_code[k].ucie;
    end

    assign o_upd_ack  = r_ack;
    assign o_busy     = r_busy;
    assign o_freeze_n = r_freeze_n;
    assign o_highz_n  = r_highz_n;

endmodule

// File: tb/tb_wphy_drvr_cal_update_seq.sv
// Directed bench for wphy_drvr_cal_update_seq: a timeline model predicts every
// output each cycle, with literal spot checks at the scheduled event cycles.
module tb_wphy_drvr_cal_update_seq;

    localparam int NCH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [1:0]  mask;
    logic [5:0]  pcal;
    logic [4:0]  ncal;
    logic [2:0]  impd;
    logic [2:0]  ovrd;
    logic [1:0]  odt;
    logic        ucie;
    logic [3:0]  settle;
    logic [1:0]  highz_req;

    logic        ack, busy;
    logic [1:0]  freeze_n, highz_n, ucie_o;
    logic [11:0] pcal_o;
    logic [9:0]  ncal_o;
    logic [5:0]  impd_o, ovrd_o;
    logic [3:0]  odt_o;

    int n_chk  = 0;
    int n_fail = 0;
    int cur;

    wphy_drvr_cal_update_seq #(.NUM_CH(NCH), .SETTLE_W(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_upd_req(req), .o_upd_ack(ack),
        .i_upd_ch_mask(mask), .i_upd_pcal(pcal), .i_upd_ncal(ncal),
        .i_upd_impd(impd), .i_upd_ovrd(ovrd), .i_upd_odt(odt), .i_upd_ucie(ucie),
        .i_settle_cyc(settle), .i_highz_req(highz_req), .o_busy(busy),
        .o_freeze_n(freeze_n), .o_highz_n(highz_n), .o_pcal(pcal_o), .o_ncal(ncal_o),
        .o_impd(impd_o), .o_ovrd(ovrd_o), .o_odt(odt_o), .o_ucie(ucie_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an update started at edge S with settle N freezes at S+1, loads
    // codes at S+2+N and releases/acks at S+3+2N (S+1 when the mask is empty).
    logic       e_valid = 1'b0;
    logic [1:0] e_freeze_n, e_highz_n;
    logic       e_ack, e_busy;
    logic [5:0] m_pcal [NCH];
    logic [4:0] m_ncal [NCH];
    logic [2:0] m_impd [NCH];
    logic [2:0] m_ovrd [NCH];
    logic [1:0] m_odt  [NCH];
    logic       m_ucie [NCH];
    logic       m_active, m_rearm;
    int         cyc = 0;
    int         m_start, m_n;
    logic [1:0] s_mask;
    logic [5:0] s_pcal;
    logic [4:0] s_ncal;
    logic [2:0] s_impd, s_ovrd;
    logic [1:0] s_odt;
    logic       s_ucie;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            e_valid    <= 1'b1;
            e_freeze_n <= 2'b11;
            e_highz_n  <= 2'b00;
            e_ack      <= 1'b0;
            e_busy     <= 1'b0;
            m_active   <= 1'b0;
            m_rearm    <= 1'b1;
            for (int k = 0; k < NCH; k++) begin
                m_pcal[k] <= 6'h20; m_ncal[k] <= 5'h10; m_impd[k] <= 3'd0;
                m_ovrd[k] <= 3'd0;  m_odt[k]  <= 2'd0;  m_ucie[k] <= 1'b0;
            end
        end else begin
            e_highz_n <= ~highz_req;
            e_ack     <= 1'b0;
            if (!req) m_rearm <= 1'b1;
            if (m_active) begin
                if (s_mask != 2'b00 && cyc - m_start == 1) e_freeze_n <= ~s_mask;
                if (s_mask != 2'b00 && cyc - m_start == 2 + m_n) begin
                    for (int k = 0; k < NCH; k++) begin
                        if (s_mask[k]) begin
                            m_pcal[k] <= s_pcal; m_ncal[k] <= s_ncal; m_impd[k] <= s_impd;
                            m_ovrd[k] <= s_ovrd; m_odt[k]  <= s_odt;  m_ucie[k] <= s_ucie;
                        end
                    end
                end
                if (cyc - m_start == ((s_mask == 2'b00) ? 1 : 3 + 2 * m_n)) begin
                    e_freeze_n <= 2'b11;
                    e_ack      <= 1'b1;
                    e_busy     <= 1'b0;
                    m_active   <= 1'b0;
                end
            end else if (req && m_rearm) begin
                m_active <= 1'b1; m_rearm <= 1'b0; e_busy <= 1'b1;
                m_start <= cyc; m_n <= int'(settle); s_mask <= mask;
                s_pcal <= pcal; s_ncal <= ncal; s_impd <= impd;
                s_ovrd <= ovrd; s_odt <= odt; s_ucie <= ucie;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [11:0] xp;
        logic [9:0]  xn;
        logic [5:0]  xi, xo;
        logic [3:0]  xd;
        logic [1:0]  xu;
        if (e_valid) begin
            for (int k = 0; k < NCH; k++) begin
                xp[k*6 +: 6] = m_pcal[k]; xn[k*5 +: 5] = m_ncal[k];
                xi[k*3 +: 3] = m_impd[k]; xo[k*3 +: 3] = m_ovrd[k];
                xd[k*2 +: 2] = m_odt[k];  xu[k]        = m_ucie[k];
            end
            chk("model_ack", 64'(ack), 64'(e_ack));
            chk("model_busy", 64'(busy), 64'(e_busy));
            chk("model_freeze_n", 64'(freeze_n), 64'(e_freeze_n));
            chk("model_highz_n", 64'(highz_n), 64'(e_highz_n));
            chk("model_pcal", 64'(pcal_o), 64'(xp));
            chk("model_ncal", 64'(ncal_o), 64'(xn));
            chk("model_impd", 64'(impd_o), 64'(xi));
            chk("model_ovrd", 64'(ovrd_o), 64'(xo));
            chk("model_odt", 64'(odt_o), 64'(xd));
            chk("model_ucie", 64'(ucie_o), 64'(xu));
        end
    end

    // Advance to the observation point of cycle k relative to the request edge.
    task automatic goto(input int k);
        repeat (k - cur) @(negedge clk);
        cur = k;
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; mask = 2'b00; pcal = 6'h00; ncal = 5'h00;
        impd = 3'd0; ovrd = 3'd0; odt = 2'd0; ucie = 1'b0; settle = 4'd0;
        highz_req = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_freeze_n", 64'(freeze_n), 64'h3);
        chk("rst_highz_n", 64'(highz_n), 64'h0);
        chk("rst_pcal", 64'(pcal_o), 64'h820);
        chk("rst_ncal", 64'(ncal_o), 64'h210);
        chk("rst_ack", 64'(ack), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full update, settle 3; inputs disturbed while busy.
        mask = 2'b11; pcal = 6'h15; ncal = 5'h10; impd = 3'd5; ovrd = 3'd2;
        odt = 2'b11; ucie = 1'b1; settle = 4'd3; req = 1'b1; cur = -1;
        goto(1);  chk("full_freeze_c1", 64'(freeze_n), 64'h0);
                  chk("full_busy_c1", 64'(busy), 64'h1);
        pcal = 6'h3F; mask = 2'b01; settle = 4'd0;
        goto(4);  chk("full_pcal_c4", 64'(pcal_o), 64'h820);
        goto(5);  chk("full_pcal_c5", 64'(pcal_o), 64'h555);
        goto(8);  chk("full_ack_c8", 64'(ack), 64'h0);
        goto(9);  chk("full_ack_c9", 64'(ack), 64'h1);
                  chk("full_freeze_c9", 64'(freeze_n), 64'h3);
        goto(10); chk("full_ack_c10", 64'(ack), 64'h0);
        req = 1'b0;
        @(negedge clk);

        // Partial update of slice 1 only, settle 0.
        mask = 2'b10; pcal = 6'h2A; ncal = 5'h07; impd = 3'd1; ovrd = 3'd4;
        odt = 2'b01; ucie = 1'b0; settle = 4'd0; req = 1'b1; cur = -1;
        goto(1); chk("part_freeze_c1", 64'(freeze_n), 64'h1);
        goto(2); chk("part_ncal_c2", 64'(ncal_o), 64'h0F0);
                 chk("part_pcal_c2", 64'(pcal_o), 64'hA95);
        goto(3); chk("part_ack_c3", 64'(ack), 64'h1);
        req = 1'b0;
        @(negedge clk);

        // Empty mask, then a held request must not retrigger.
        mask = 2'b00; pcal = 6'h01; req = 1'b1; cur = -1;
        goto(1); chk("empty_ack_c1", 64'(ack), 64'h1);
                 chk("empty_freeze_c1", 64'(freeze_n), 64'h3);
        for (int i = 2; i < 12; i++) begin
            goto(i); chk("hold_no_ack", 64'(ack), 64'h0);
        end
        chk("empty_pcal_kept", 64'(pcal_o), 64'hA95);
        req = 1'b0;
        @(negedge clk);
        mask = 2'b01; pcal = 6'h0C; settle = 4'd1; req = 1'b1; cur = -1;
        goto(1); chk("rearm_freeze_c1", 64'(freeze_n), 64'h2);
        goto(3); chk("rearm_pcal_c3", 64'(pcal_o), 64'hA8C);
        goto(5); chk("rearm_ack_c5", 64'(ack), 64'h1);
        req = 1'b0;
        @(negedge clk);

        // Reset asserted while in the first settle phase.
        mask = 2'b11; settle = 4'd5; req = 1'b1; cur = -1;
        goto(2); chk("midrst_freeze_c2", 64'(freeze_n), 64'h0);
        rst_n = 1'b0; req = 1'b0;
        goto(3); chk("midrst_freeze", 64'(freeze_n), 64'h3);
                 chk("midrst_pcal", 64'(pcal_o), 64'h820);
                 chk("midrst_ack", 64'(ack), 64'h0);
                 chk("midrst_busy", 64'(busy), 64'h0);
        rst_n = 1'b1;
        goto(20); chk("midrst_no_ack", 64'(ack), 64'h0);

        // High-Z pulse during the second settle phase.
        mask = 2'b11; pcal = 6'h33; settle = 4'd2; req = 1'b1; cur = -1;
        goto(4); chk("hz_pcal_c4", 64'(pcal_o), 64'hCF3);
        highz_req = 2'b01;
        goto(5); chk("hz_highz_c5", 64'(highz_n), 64'h2);
                 chk("hz_ack_c5", 64'(ack), 64'h0);
        highz_req = 2'b00;
        goto(6); chk("hz_highz_c6", 64'(highz_n), 64'h3);
        goto(7); chk("hz_ack_c7", 64'(ack), 64'h1);
                 chk("hz_freeze_c7", 64'(freeze_n), 64'h3);
        req = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wphy_drvr_cal_update_seq.md
Name: wphy_drvr_cal_update_seq

Overview:
Synchronous controller that applies new driver calibration and mode codes (pcal/ncal/impd/ovrd/ODT/UCIe enable) to NUM_CH DQ/DQS driver slices without glitching the pads.
Each update follows a fixed sequence: freeze the targeted slices, let them settle, load the new codes, settle again, then release.
It sits in the digital PHY control domain and drives the freeze_n, highz_n and code inputs of the driver slices.
It also owns per-channel high-Z control.

Parameters:
NUM_CH, 2, number of driver slices controlled
PCAL_W, 6, pull-up cal code width
NCAL_W, 5, pull-down cal code width
IMPD_W, 3, drive impedance select width
OVRD_W, 3, override code width
ODT_W, 2, UCIe ODT enable width
SETTLE_W, 4, settle counter width
PCAL_RST, 6'h20, pcal reset code
NCAL_RST, 5'h10, ncal reset code

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; synchronous, active-low
i_upd_req  in  1  update request (level)
o_upd_ack  out  1  one-cycle completion pulse
i_upd_ch_mask  in  NUM_CH  slices to update
i_upd_pcal  in  PCAL_W  new pcal
i_upd_ncal  in  NCAL_W  new ncal
i_upd_impd  in  IMPD_W  new impedance select
i_upd_ovrd  in  OVRD_W  new override
i_upd_odt  in  ODT_W  new UCIe ODT enable
i_upd_ucie  in  1  new UCIe mode enable
i_settle_cyc  in  SETTLE_W  settle wait cycles
i_highz_req  in  NUM_CH  per-slice high-Z request
o_busy  out  1  FSM not IDLE
o_freeze_n  out  NUM_CH  per-slice freeze_n
o_highz_n  out  NUM_CH  per-slice highz_n
o_pcal  out  NUM_CH*PCAL_W  per-slice pcal, slice k at [k*PCAL_W +: PCAL_W]
o_ncal  out  NUM_CH*NCAL_W  per-slice ncal
o_impd  out  NUM_CH*IMPD_W  per-slice impd
o_ovrd  out  NUM_CH*OVRD_W  per-slice ovrd
o_odt  out  NUM_CH*ODT_W  per-slice ODT enable
o_ucie  out  NUM_CH  per-slice UCIe enable

Behaviour:
- Reset values (i_rst_n low at a clock edge):
  - FSM=IDLE
  - o_freeze_n=all 1, o_highz_n=all 0, o_upd_ack=0, o_busy=0
  - o_pcal=PCAL_RST and o_ncal=NCAL_RST for every slice; o_impd, o_ovrd, o_odt and o_ucie=0
  - settle counter=0, rearm flag=1
- All outputs are registered.
- FSM states: IDLE, FREEZE, SET_PRE, APPLY, SET_POST, RELEASE.
- IDLE: when i_upd_req=1 and rearm=1:
  - latch mask, all code inputs and i_settle_cyc into shadow registers; clear rearm.
  - If the latched mask is 0: go to RELEASE directly; no freeze, codes unchanged.
  - Otherwise go to FREEZE.
- FREEZE: o_freeze_n[k]=0 for masked k; load counter with settle value; go to SET_PRE.
- SET_PRE: decrement counter; leave when counter==0 (settle value 0 means zero wait cycles).
- APPLY: masked slices' code registers load shadow values; unmasked slices hold. Reload counter; go to SET_POST.
- SET_POST: same as SET_PRE, then go to RELEASE.
- RELEASE: o_freeze_n=all 1, o_upd_ack=1 for exactly one cycle, return to IDLE.
- Timing, with request sampled at edge 0 and N=i_settle_cyc:
  - freeze_n low visible in cycle 1
  - codes change in cycle 2+N
  - freeze_n high and ack in cycle 3+2N
  - mask=0 gives ack in cycle 1.
- Rearm: set when i_upd_req is sampled 0. A level request held high after ack does not start a second update.
- Inputs changing while busy are ignored; the shadow copy is used.
- o_highz_n[k] <= ~i_highz_req[k] every cycle, independent of FSM state (1-cycle latency). High-Z during an update does not abort it.
- o_busy=1 in every state except IDLE.
- Reset asserted mid-update: FSM returns to IDLE on the next edge, all outputs go to reset values, and no ack is issued.

Decomposition:
- Package wphy_drvr_cal_pkg holds:
  - FSM state enum (state_t)
  - a drvr_code_t struct {pcal, ncal, impd, ovrd, odt, ucie} with width localparams
  - reset code constants
- One sub-module, wphy_drvr_cal_slice_reg: per-slice code register with load enable and reset defaults, instantiated NUM_CH times via generate.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles -> freeze_n=2'b11, highz_n=2'b00, pcal=6'h20 on both slices, ncal=5'h10, ack=0, busy=0.
- Full update: mask=2'b11, pcal=6'h15, settle=3, req 0->1 -> freeze_n=00 in cycle 1, pcal=15 in cycle 5, freeze_n=11 and single ack in cycle 9.
- Partial update: mask=2'b10, ncal=5'h07, settle=0 -> only slice1 freezes and gets ncal=07; slice0 keeps freeze_n=1 and ncal=10; ack in cycle 3.
- Empty mask and rearm: mask=0 -> ack in cycle 1, codes unchanged. Hold req high 10 cycles -> no second ack. Drop and re-raise req -> new update starts.
- Reset mid-op: assert i_rst_n=0 during SET_PRE -> freeze_n=11 and reset codes next cycle; no ack.
- High-Z during update: i_highz_req=2'b01 pulsed during SET_POST -> highz_n=2'b10 one cycle later; update completes with ack on schedule.
